// File: rtl/output_port.sv
// Router output port: round-robin arbitration of head flits, packet lock until tail,
// and a first-word fall-through FIFO toward the link.
module output_port #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] dataIn0,
    input  logic [16:0] dataIn1,
    input  logic [16:0] dataIn2,
    input  logic [16:0] dataIn3,
    input  logic [16:0] dataIn4,
    input  logic [4:0]  request,
    input  logic        readyIn,
    output logic [4:0]  grant,
    output logic        available,
    output logic        ready,
    output logic [15:0] dataOut,
    output logic        validOut
);
    localparam int unsigned NPORTS = 5;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [16:0]   din [NPORTS];
    logic [2:0]    winner;
    logic          found;
    logic          push;
    logic          pop;
    logic [15:0]   push_data;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [15:0]   mem [DEPTH];

    assign din[0] = dataIn0;
    assign din[1] = dataIn1;
    assign din[2] = dataIn2;
    assign din[3] = dataIn3;
    assign din[4] = dataIn4;

    function automatic logic is_head(input logic [15:0] f);
        return f[15:14] == 2'b11;
    endfunction

    function automatic logic is_tail(input logic [15:0] f);
        return f[15:14] == 2'b10;
    endfunction

    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p >= 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

    // Round-robin search starting at ptr for a valid, requesting head flit
    always_comb begin
        logic [2:0] idx;
        idx    = ptr_q;
        winner = 3'd0;
        found  = 1'b0;
        for (int k = 0; k < int'(NPORTS); k++) begin
            if (!found && request[idx] && din[idx][16] && is_head(din[idx][15:0])) begin
                found  = 1'b1;
                winner = idx;
            end
            idx = next_port(idx);
        end
    end

    // Lock FSM: next state, owner/pointer update, grant and push
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        push      = 1'b0;
        push_data = din[owner_q][15:0];
        grant     = 5'b00000;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant = 5'b00001 << winner;
                    if (ready) begin
                        push      = 1'b1;
                        push_data = din[winner][15:0];
                        owner_d   = winner;
                        ptr_d     = next_port(winner);
                        state_d   = LOCKED;
                    end
                end
            end
            LOCKED: begin
                grant = 5'b00001 << owner_q;
                if (din[owner_q][16] && ready) begin
                    push = 1'b1;
                    if (is_tail(din[owner_q][15:0])) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!reset) begin
            grant = 5'b00000;
            push  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 3'd0;
            ptr_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign available = (state_q == IDLE);
    assign ready     = (count_q < CW'(DEPTH));
    assign validOut  = (count_q != '0);
    assign dataOut   = validOut ? mem[rd_ptr_q] : 16'h0000;
    assign pop       = validOut & readyIn;

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

endmodule
